// File: rtl/ntt_ctrl_pkg.sv
// ntt_ctrl_pkg: shared types and address arithmetic for the NTT stage sequencer.
//   ntt_state_t   - sequencer states (IDLE, RUN, DRAIN, DONE)
//   ntt_addr_t    - {addr0, addr1, tw} result of one butterfly address computation
//   ntt_addr_calc - butterfly address pair and twiddle index for stage s, index j
package ntt_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ntt_state_t;

    // Fields are kept 32 bits wide so the function is independent of LOGN;
    // callers size-cast each field down to their port width.
    typedef struct packed {
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] tw;
    } ntt_addr_t;

    // Cooley-Tukey in-place butterfly addressing:
    //   k = j mod 2^s picks the position inside a group,
    //   g = j / 2^s picks the group; groups are 2^(s+1) apart,
    //   the lower leg sits 2^s above the upper leg,
    //   twiddle stride shrinks by 2 each stage.
    function automatic ntt_addr_t ntt_addr_calc(input logic [31:0] s,
                                                input logic [31:0] j,
                                                input logic [31:0] logn);
        ntt_addr_t   r;
        logic [31:0] k;
        logic [31:0] g;
        k       = j & ((32'd1 << s) - 32'd1);
        g       = j >> s;
        r.addr0 = (g << (s + 32'd1)) | k;
        r.addr1 = r.addr0 + (32'd1 << s);
        r.tw    = k << (logn - 32'd1 - s);
        return r;
    endfunction

endpackage

// File: rtl/ntt_ctrl_delay.sv
// ntt_ctrl_delay: WIDTH x DEPTH shift register with a valid lane.
//   clk, reset - clock, synchronous active-high reset (clears valid and data)
//   en         - shift enable; when low every tap holds
//   in_valid   - valid bit entering tap 0
//   in_data    - payload entering tap 0
//   out_valid  - valid bit at the last tap (DEPTH cycles after entry)
//   out_data   - payload at the last tap
module ntt_ctrl_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (en) begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// ntt_stage_ctrl: sequencer for an in-place radix-2 Cooley-Tukey NTT over
// 2^LOGN coefficients. One butterfly is issued per cycle; a drain gap of
// PIPE_DELAY cycles separates stages so that the last write of a stage lands
// before the first read of the next.
//
// Optional feature macro: NTT_STALL_EN adds a 'stall' input that freezes the
// sequencer and the write-back delay pipe.
//
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   start              - begin a transform (only honoured in IDLE)
//   stall              - (NTT_STALL_EN only) freeze everything, mask strobes
//   busy               - high from the cycle after start through DONE
//   done               - one-cycle pulse after the final write-back
//   rd_en              - butterfly issue strobe
//   rd_addr0/rd_addr1  - upper/lower leg coefficient read addresses
//   tw_addr            - twiddle ROM address
//   seq_mode           - routing mode for the seq unit (stage parity)
//   stage              - current stage index
//   wr_en              - write-back strobe
//   wr_addr0/wr_addr1  - read addresses delayed by PIPE_DELAY
module ntt_stage_ctrl
    import ntt_ctrl_pkg::*;
#(
    parameter int LOGQ       = 17,
    parameter int LOGN       = 8,
    parameter int PIPE_DELAY = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
`ifdef NTT_STALL_EN
    input  logic                    stall,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [LOGN-1:0]         rd_addr0,
    output logic [LOGN-1:0]         rd_addr1,
    output logic [LOGN-2:0]         tw_addr,
    output logic                    seq_mode,
    output logic [$clog2(LOGN)-1:0] stage,
    output logic                    wr_en,
    output logic [LOGN-1:0]         wr_addr0,
    output logic [LOGN-1:0]         wr_addr1
);

    localparam int SW = $clog2(LOGN);
    localparam int JW = LOGN - 1;
    localparam int CW = $clog2(PIPE_DELAY + 1);

    localparam logic [JW-1:0] J_LAST   = '1;
    localparam logic [SW-1:0] S_LAST   = SW'(LOGN - 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(PIPE_DELAY - 1);

    if (LOGN < 2 || PIPE_DELAY < 1 || LOGQ < 1) begin : g_bad_param
        $error("ntt_stage_ctrl: LOGN must be >= 2, PIPE_DELAY >= 1, LOGQ >= 1");
    end

    // hold freezes sequencer and delay pipe; without the feature it is tied low.
    logic hold;
`ifdef NTT_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    ntt_state_t    state, state_next;
    logic [SW-1:0] s, s_next;
    logic [JW-1:0] j, j_next;
    logic [CW-1:0] cnt, cnt_next;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            s     <= '0;
            j     <= '0;
            cnt   <= '0;
        end else if (!hold) begin
            state <= state_next;
            s     <= s_next;
            j     <= j_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        s_next     = s;
        j_next     = j;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    s_next     = '0;
                    j_next     = '0;
                end
            end
            RUN: begin
                if (j == J_LAST) begin
                    state_next = DRAIN;
                    cnt_next   = CNT_INIT;
                end else begin
                    j_next = j + JW'(1);
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    if (s == S_LAST) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                        s_next     = s + SW'(1);
                        j_next     = '0;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            DONE: begin
                // start is deliberately not looked at here
                state_next = IDLE;
                s_next     = '0;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    ntt_addr_t addr;

    always_comb begin
        addr     = ntt_addr_calc(32'(s), 32'(j), 32'(LOGN));
        busy     = (state != IDLE);
        done     = (state == DONE) && !hold;
        rd_en    = (state == RUN) && !hold;
        stage    = s;
        rd_addr0 = '0;
        rd_addr1 = '0;
        tw_addr  = '0;
        seq_mode = 1'b0;
        if (state == RUN) begin
            rd_addr0 = LOGN'(addr.addr0);
            rd_addr1 = LOGN'(addr.addr1);
            tw_addr  = (LOGN-1)'(addr.tw);
            seq_mode = s[0];
        end
    end

    // Write-back delay pipe: carries the issue strobe and address pair.
    logic              pipe_valid;
    logic [2*LOGN-1:0] pipe_data;

    ntt_ctrl_delay #(
        .WIDTH (2 * LOGN),
        .DEPTH (PIPE_DELAY)
    ) u_delay (
        .clk       (clk),
        .reset     (reset),
        .en        (!hold),
        .in_valid  (rd_en),
        .in_data   ({rd_addr0, rd_addr1}),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    assign wr_en    = pipe_valid && !hold;
    assign wr_addr0 = pipe_data[2*LOGN-1:LOGN];
    assign wr_addr1 = pipe_data[LOGN-1:0];

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Directed testbench for ntt_stage_ctrl with LOGN=3, PIPE_DELAY=2.
// Stage schedule relative to start acceptance (cycle 0): RUN 1-4, 7-10,
// 13-16; DRAIN 5-6, 11-12, 17-18; DONE 19. Address tables are hand-derived.
module tb_ntt_stage_ctrl;

    localparam int LOGN = 3;
    localparam int PD   = 2;

    logic       clk;
    logic       reset;
    logic       start;
`ifdef NTT_STALL_EN
    logic       stall;
`endif
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [2:0] rd_addr0;
    logic [2:0] rd_addr1;
    logic [1:0] tw_addr;
    logic       seq_mode;
    logic [1:0] stage;
    logic       wr_en;
    logic [2:0] wr_addr0;
    logic [2:0] wr_addr1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int wr_cnt = 0;

    logic [5:0] exp_q[$];

    // Hand-computed butterfly table, index = stage*4 + j
    logic [2:0] a0_tab [12] = '{3'd0, 3'd2, 3'd4, 3'd6,
                                3'd0, 3'd1, 3'd4, 3'd5,
                                3'd0, 3'd1, 3'd2, 3'd3};
    logic [2:0] a1_tab [12] = '{3'd1, 3'd3, 3'd5, 3'd7,
                                3'd2, 3'd3, 3'd6, 3'd7,
                                3'd4, 3'd5, 3'd6, 3'd7};
    logic [1:0] tw_tab [12] = '{2'd0, 2'd0, 2'd0, 2'd0,
                                2'd0, 2'd2, 2'd0, 2'd2,
                                2'd0, 2'd1, 2'd2, 2'd3};

    ntt_stage_ctrl #(
        .LOGQ       (17),
        .LOGN       (LOGN),
        .PIPE_DELAY (PD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef NTT_STALL_EN
        .stall    (stall),
`endif
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .tw_addr  (tw_addr),
        .seq_mode (seq_mode),
        .stage    (stage),
        .wr_en    (wr_en),
        .wr_addr0 (wr_addr0),
        .wr_addr1 (wr_addr1)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {busy, done, rd_en, rd_addr0, rd_addr1, tw_addr, seq_mode,
                  stage, wr_en, wr_addr0, wr_addr1}, 32'd0);
    endtask

    // Checks every output at cycle r of an unstalled pass (start accepted at r=0).
    task automatic check_pass(input int r);
        int   s_e;
        int   p;
        int   idx;
        logic e_rd;
        logic e_wr;
        logic [5:0] pair;
        s_e  = (r - 1) / 6;
        p    = (r - 1) % 6;
        e_rd = (r >= 1) && (r <= 18) && (p < 4);
        e_wr = (r >= 3) && (r <= 18) && (((r - 3) % 6) < 4);
        chk("busy", busy, (r >= 1) && (r <= 19));
        chk("done", done, r == 19);
        chk("rd_en", rd_en, e_rd);
        chk("wr_en", wr_en, e_wr);
        if (e_rd) begin
            idx  = s_e * 4 + p;
            pair = {a0_tab[idx], a1_tab[idx]};
            chk("rd_pair", {rd_addr0, rd_addr1}, pair);
            chk("tw_addr", tw_addr, tw_tab[idx]);
            chk("seq_mode", seq_mode, s_e == 1);
            chk("stage", stage, s_e);
            exp_q.push_back(pair);
        end else begin
            chk("idle_rd_outputs", {rd_addr0, rd_addr1, tw_addr, seq_mode}, 32'd0);
        end
        if (e_wr) begin
            wr_cnt++;
            chk("wr_q_nonempty", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                chk("wr_pair", {wr_addr0, wr_addr1}, exp_q.pop_front());
            end
        end
    endtask

    task automatic full_pass();
        wr_cnt = 0;
        exp_q.delete();
        cyc    = 0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int r = 1; r <= 21; r++) begin
            check_pass(r);
            step();
        end
        chk("wr_pulse_count", wr_cnt, 12);
        chk("wr_q_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic seen;
        reset = 1'b1;
        start = 1'b0;
`ifdef NTT_STALL_EN
        stall = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
        chk_all_zero("reset_state");
        step();
        chk_all_zero("idle_after_reset");

        // Pass with a single start pulse
        full_pass();

        // start held high: DONE at 19 ignores it, IDLE at 20 accepts it
        cyc   = 0;
        start = 1'b1;
        step();
        exp_q.delete();
        for (int r = 1; r <= 19; r++) begin
            check_pass(r);
            step();
        end
        chk("held_start_idle_busy", busy, 1'b0);
        chk("held_start_idle_rd", rd_en, 1'b0);
        step();
        chk("second_pass_busy", busy, 1'b1);
        chk("second_pass_rd_en", rd_en, 1'b1);
        chk("second_pass_first_pair", {rd_addr0, rd_addr1, stage}, {3'd0, 3'd1, 2'd0});
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        chk("second_pass_done_seen", seen, 1'b1);
        chk("second_pass_done_cycle", cyc, 39);
        step();

        // Reset in the middle of stage 1
        exp_q.delete();
        cyc   = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int r = 1; r <= 8; r++) begin
            check_pass(r);
            if (r == 8) reset = 1'b1;
            step();
        end
        reset = 1'b0;
        for (int c = 9; c <= 12; c++) begin
            chk_all_zero("after_abort");
            if (c < 12) step();
        end
        full_pass();

`ifdef NTT_STALL_EN
        // Stall during cycles 3-5 of a pass
        cyc   = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("stall_c1_pair", {rd_en, rd_addr0, rd_addr1}, {1'b1, 3'd0, 3'd1});
        step();
        chk("stall_c2_pair", {rd_en, rd_addr0, rd_addr1}, {1'b1, 3'd2, 3'd3});
        step();
        for (int c = 3; c <= 5; c++) begin
            stall = 1'b1;
            #1;
            chk("stalled_strobes", {rd_en, wr_en, done}, 3'b000);
            chk("stalled_busy", busy, 1'b1);
            step();
        end
        stall = 1'b0;
        #1;
        chk("resume_pair", {rd_en, rd_addr0, rd_addr1}, {1'b1, 3'd4, 3'd5});
        chk("resume_wr", {wr_en, wr_addr0, wr_addr1}, {1'b1, 3'd0, 3'd1});
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        chk("stall_done_seen", seen, 1'b1);
        chk("stall_done_cycle", cyc, 22);
        step();
        chk("stall_back_idle", busy, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
